// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// opcode constants, immediate-generator selects and ALU operation codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_ILLEGAL
    } state_t;

    // ALU operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Immediate generator selects (shared with the datapath)
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Only beq and bne are implemented among the branch encodings
    function automatic logic isSupportedBranch(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to the ALU
// control code. Unimplemented funct3 values quietly fall back to add.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_t      aluOp,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        opb5,
    output logic [2:0]  aluControl
);

    // Select the ALU operation; sub only for R-type with inst[30] set
    always_comb begin
        aluControl = ALU_ADD;
        unique case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3)
                    3'b000:  aluControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath. Sequences fetch,
// decode, execute, memory and writeback, stalls on memReady, and counts
// retired instructions.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic             memWrite,
    output logic             adrSrc,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       immSrc,
    output logic [2:0]       aluControl,
    output logic             retired,
    output logic [CNT_W-1:0] instCount,
    output logic             illegal
);

    state_t state;
    state_t nextState;
    aluop_t aluOp;
    logic   pcWriteRaw;
    logic   irWriteRaw;
    logic   regWriteRaw;
    logic   memWriteRaw;

    alu_decoder u_alu_decoder (
        .aluOp      (aluOp),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opb5       (opcode[5]),
        .aluControl (aluControl)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and Moore output decode, with memReady/zero gating
    always_comb begin
        nextState   = state;
        pcWriteRaw  = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        memWriteRaw = 1'b0;
        adrSrc      = 1'b0;
        resultSrc   = 2'b00;
        aluSrcA     = 2'b00;
        aluSrcB     = 2'b00;
        immSrc      = IMM_I;
        aluOp       = ALUOP_ADD;
        retired     = 1'b0;
        illegal     = 1'b0;
        unique case (state)
            S_FETCH: begin
                aluSrcB    = 2'b10;
                resultSrc  = 2'b10;
                irWriteRaw = memReady;
                pcWriteRaw = memReady;
                if (memReady) nextState = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                immSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                unique case (opcode)
                    OP_LOAD, OP_STORE: nextState = S_MEMADR;
                    OP_RTYPE:          nextState = S_EXECR;
                    OP_ITYPE:          nextState = S_EXECI;
                    OP_BRANCH:         nextState = isSupportedBranch(funct3) ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:            nextState = S_JAL;
                    OP_LUI:            nextState = S_LUI;
                    default:           nextState = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                immSrc    = (opcode == OP_STORE) ? IMM_S : IMM_I;
                nextState = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                if (memReady) nextState = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc   = 2'b01;
                regWriteRaw = 1'b1;
                retired     = 1'b1;
                nextState   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc      = 1'b1;
                memWriteRaw = 1'b1;
                retired     = memReady;
                if (memReady) nextState = S_FETCH;
            end
            S_EXECR: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b00;
                aluOp     = ALUOP_FUNCT;
                nextState = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                aluOp     = ALUOP_FUNCT;
                nextState = S_ALUWB;
            end
            S_ALUWB: begin
                resultSrc   = 2'b00;
                regWriteRaw = 1'b1;
                retired     = 1'b1;
                nextState   = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA    = 2'b10;
                aluSrcB    = 2'b00;
                aluOp      = ALUOP_SUB;
                pcWriteRaw = (funct3 == F3_BNE) ? !zero : zero;
                retired    = 1'b1;
                nextState  = S_FETCH;
            end
            S_JAL: begin
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b10;
                pcWriteRaw = 1'b1;
                nextState  = S_ALUWB;
            end
            S_LUI: begin
                aluSrcA   = 2'b11;
                aluSrcB   = 2'b01;
                immSrc    = IMM_U;
                nextState = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal   = 1'b1;
                nextState = S_ILLEGAL;
            end
            default: nextState = S_FETCH;
        endcase
    end

    // Write strobes are suppressed while reset is held so nothing is
    // committed by a half-reset datapath
    assign pcWrite  = pcWriteRaw  & rst_n;
    assign irWrite  = irWriteRaw  & rst_n;
    assign regWrite = regWriteRaw & rst_n;
    assign memWrite = memWriteRaw & rst_n;

    // Retired-instruction counter, wrapping naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instCount <= '0;
        end else if (retired) begin
            instCount <= instCount + CNT_W'(1);
        end
    end

endmodule
